// File: rtl/ppc_types_pkg.sv
// Shared processor-wide types and constants used by the result broadcaster.
package ppc_types;

    localparam int unsigned CDB_DATA_WIDTH = 32;

    typedef logic [CDB_DATA_WIDTH-1:0] cdb_data_t;

    // Index width that stays at least one bit wide for single-entry sets.
    function automatic int unsigned index_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/result_broadcaster_fifo.sv
// result_fifo: single-clock circular buffer with push, pop, occupancy count and empty flag.
module result_fifo
    import ppc_types::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 37
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty
);

    localparam int unsigned PTR_W = index_width(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    // A full buffer refuses pushes even when it is popped in the same cycle.
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/result_broadcaster.sv
// Common-data-bus transmitter: per-unit result FIFOs, round-robin arbitration, one broadcast per cycle.
// CDB_OUTPUT_REG_EN adds a register stage on the cdb_* outputs.
module result_broadcaster
    import ppc_types::*;
#(
    parameter int unsigned UNITS       = 4,
    parameter int unsigned FIFO_DEPTH  = 2,
    parameter int unsigned RS_ID_WIDTH = 5
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [UNITS-1:0]                        result_valid,
    output logic [UNITS-1:0]                        result_ready,
    input  logic [UNITS-1:0][RS_ID_WIDTH-1:0]       result_rs_id,
    input  logic [UNITS-1:0][CDB_DATA_WIDTH-1:0]    result_value,
    output logic                                    cdb_valid,
    output logic [RS_ID_WIDTH-1:0]                  cdb_rs_id,
    output logic [CDB_DATA_WIDTH-1:0]               cdb_value,
    output logic [index_width(UNITS)-1:0]           cdb_unit
);

    localparam int unsigned UNIT_W = index_width(UNITS);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [RS_ID_WIDTH-1:0] rs_id;
        cdb_data_t              value;
    } entry_t;

    localparam int unsigned ENTRY_W = $bits(entry_t);

    logic [ENTRY_W-1:0] head [UNITS];
    logic [CNT_W-1:0]   count [UNITS];
    logic [UNITS-1:0]   empty;
    logic [UNITS-1:0]   pop;

    logic               win_valid;
    logic [UNIT_W-1:0]  win_unit;
    entry_t             win_entry;
    logic [UNIT_W-1:0]  rr_ptr;

    logic                      cdb_valid_c;
    logic [RS_ID_WIDTH-1:0]    cdb_rs_id_c;
    logic [CDB_DATA_WIDTH-1:0] cdb_value_c;
    logic [UNIT_W-1:0]         cdb_unit_c;

    for (genvar k = 0; k < int'(UNITS); k++) begin : g_unit
        entry_t wentry;

        assign wentry.rs_id    = result_rs_id[k];
        assign wentry.value    = result_value[k];
        assign result_ready[k] = (count[k] != CNT_W'(FIFO_DEPTH));

        result_fifo #(
            .DEPTH (FIFO_DEPTH),
            .WIDTH (ENTRY_W)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (result_valid[k]),
            .pop   (pop[k]),
            .wdata (wentry),
            .rdata (head[k]),
            .count (count[k]),
            .empty (empty[k])
        );
    end

    // Round-robin search starting at rr_ptr; first non-empty FIFO wins.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        win_valid = 1'b0;
        win_unit  = '0;
        for (int unsigned i = 0; i < UNITS; i++) begin
            idx = (32'(rr_ptr) + i) % UNITS;
            if (!win_valid && !empty[idx]) begin
                win_valid = 1'b1;
                win_unit  = UNIT_W'(idx);
            end
        end
    end

    always_comb begin
        pop = '0;
        if (win_valid) begin
            pop[win_unit] = 1'b1;
        end
    end

    assign win_entry = entry_t'(head[win_unit]);

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (win_valid) begin
            rr_ptr <= (win_unit == UNIT_W'(UNITS - 1)) ? '0 : win_unit + UNIT_W'(1);
        end
    end

    // Idle bus drives zeros on every payload field.
    always_comb begin
        cdb_valid_c = win_valid;
        cdb_rs_id_c = '0;
        cdb_value_c = '0;
        cdb_unit_c  = '0;
        if (win_valid) begin
            cdb_rs_id_c = win_entry.rs_id;
            cdb_value_c = win_entry.value;
            cdb_unit_c  = win_unit;
        end
    end

`ifdef CDB_OUTPUT_REG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cdb_valid <= 1'b0;
            cdb_rs_id <= '0;
            cdb_value <= '0;
            cdb_unit  <= '0;
        end else begin
            cdb_valid <= cdb_valid_c;
            cdb_rs_id <= cdb_rs_id_c;
            cdb_value <= cdb_value_c;
            cdb_unit  <= cdb_unit_c;
        end
    end
`else
    assign cdb_valid = cdb_valid_c;
    assign cdb_rs_id = cdb_rs_id_c;
    assign cdb_value = cdb_value_c;
    assign cdb_unit  = cdb_unit_c;
`endif

endmodule

// File: tb/tb_result_broadcaster.sv
// Self-checking bench for result_broadcaster: queue-based reference model plus directed scenarios.
module tb_result_broadcaster;

    localparam int UNITS = 4;
    localparam int DEPTH = 2;
    localparam int RSW   = 5;
`ifdef CDB_OUTPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic                        clk;
    logic                        rst;
    logic [UNITS-1:0]            result_valid;
    logic [UNITS-1:0]            result_ready;
    logic [UNITS-1:0][RSW-1:0]   result_rs_id;
    logic [UNITS-1:0][31:0]      result_value;
    logic                        cdb_valid;
    logic [RSW-1:0]              cdb_rs_id;
    logic [31:0]                 cdb_value;
    logic [1:0]                  cdb_unit;

    result_broadcaster #(
        .UNITS       (UNITS),
        .FIFO_DEPTH  (DEPTH),
        .RS_ID_WIDTH (RSW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result_rs_id (result_rs_id),
        .result_value (result_value),
        .cdb_valid    (cdb_valid),
        .cdb_rs_id    (cdb_rs_id),
        .cdb_value    (cdb_value),
        .cdb_unit     (cdb_unit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;
    bit saw_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: visible entries per unit as queues, plus round-robin pointer.
    logic [36:0] mq [UNITS][$];
    int          mrr = 0;
    bit          pipe_v = 0;
    logic [36:0] pipe_e = '0;
    int          pipe_u = 0;
    logic [31:0] ulog [UNITS][$];

    function automatic int model_winner();
        for (int i = 0; i < UNITS; i++) begin
            if (mq[(mrr + i) % UNITS].size() > 0) return (mrr + i) % UNITS;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        int w;
        int sz [UNITS];
        if (rst) begin
            for (int k = 0; k < UNITS; k++) mq[k].delete();
            mrr    = 0;
            pipe_v = 0;
            pipe_e = '0;
            pipe_u = 0;
        end else begin
            for (int k = 0; k < UNITS; k++) sz[k] = mq[k].size();
            w      = model_winner();
            pipe_v = (w >= 0);
            pipe_e = (w >= 0) ? mq[w][0] : '0;
            pipe_u = (w >= 0) ? w : 0;
            if (w >= 0) begin
                void'(mq[w].pop_front());
                mrr = (w + 1) % UNITS;
            end
            for (int k = 0; k < UNITS; k++) begin
                if (result_valid[k] && sz[k] != DEPTH)
                    mq[k].push_back({result_rs_id[k], result_value[k]});
            end
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        int          w;
        bit          ev;
        logic [36:0] ee;
        int          eu;
        logic [3:0]  erdy;
        if (cmp_en) begin
`ifdef CDB_OUTPUT_REG_EN
            w  = 0;
            ev = pipe_v;
            ee = pipe_e;
            eu = pipe_u;
`else
            w  = model_winner();
            ev = (w >= 0);
            ee = ev ? mq[w][0] : '0;
            eu = ev ? w : 0;
`endif
            for (int k = 0; k < UNITS; k++) erdy[k] = (mq[k].size() != DEPTH);
            chk("model_cdb_valid", 64'(cdb_valid), 64'(ev));
            chk("model_cdb_rs_id", 64'(cdb_rs_id), 64'(ee[36:32]));
            chk("model_cdb_value", 64'(cdb_value), 64'(ee[31:0]));
            chk("model_cdb_unit",  64'(cdb_unit),  64'(eu));
            chk("model_ready",     64'(result_ready), 64'(erdy));
            if (cdb_valid) begin
                ulog[cdb_unit].push_back(cdb_value);
                if (cdb_value == 32'hBAD0_0002 || cdb_value == 32'hBAD0_0003) saw_bad = 1;
            end
        end
    end

    task automatic clear_inputs();
        result_valid = '0;
        result_rs_id = '0;
        result_value = '0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        cmp_en = 1;

        // Reset state
        chk("rst_valid", 64'(cdb_valid), 64'd0);
        chk("rst_rs_id", 64'(cdb_rs_id), 64'd0);
        chk("rst_value", 64'(cdb_value), 64'd0);
        chk("rst_unit",  64'(cdb_unit),  64'd0);
        chk("rst_ready", 64'(result_ready), 64'hF);
        rst = 1'b0;
        @(negedge clk);

        // Single uncontended result from unit 2
        result_valid[2] = 1'b1;
        result_rs_id[2] = 5'd5;
        result_value[2] = 32'hDEAD_BEEF;
        @(negedge clk);
        clear_inputs();
        repeat (LAT - 1) @(negedge clk);
        chk("single_valid", 64'(cdb_valid), 64'd1);
        chk("single_rs_id", 64'(cdb_rs_id), 64'd5);
        chk("single_value", 64'(cdb_value), 64'hDEAD_BEEF);
        chk("single_unit",  64'(cdb_unit),  64'd2);
        @(negedge clk);
        chk("single_after", 64'(cdb_valid), 64'd0);

        // Four-way contention from rr_ptr = 0
        pulse_reset();
        for (int k = 0; k < UNITS; k++) begin
            result_valid[k] = 1'b1;
            result_rs_id[k] = RSW'(10 + k);
            result_value[k] = 32'h1000 + 32'(k);
        end
        @(negedge clk);
        clear_inputs();
        repeat (LAT - 1) @(negedge clk);
        for (int k = 0; k < UNITS; k++) begin
            chk("cont_unit",  64'(cdb_unit),  64'(k));
            chk("cont_rs_id", 64'(cdb_rs_id), 64'(10 + k));
            @(negedge clk);
        end
        chk("cont_idle", 64'(cdb_valid), 64'd0);

        // Fairness: units 1 and 3 push every cycle
        for (int n = 0; n < 12; n++) begin
            result_valid    = 4'b1010;
            result_rs_id[1] = 5'd1;
            result_rs_id[3] = 5'd3;
            result_value[1] = 32'h1100 + 32'(n);
            result_value[3] = 32'h3300 + 32'(n);
            @(negedge clk);
            if (n >= LAT - 1)
                chk("fair_unit", 64'(cdb_unit), ((n - (LAT - 1)) % 2 == 0) ? 64'd1 : 64'd3);
        end
        clear_inputs();
        repeat (8) @(negedge clk);
        chk("fair_drained", 64'(cdb_valid), 64'd0);

        // Backpressure on unit 0 while unit 1 competes
        pulse_reset();
        for (int k = 0; k < UNITS; k++) ulog[k].delete();
        result_valid    = 4'b0001;
        result_value[0] = 32'hA000;
        @(negedge clk);
        result_valid    = 4'b0011;
        result_rs_id[1] = 5'd1;
        result_value[0] = 32'hA001;
        result_value[1] = 32'hB001;
        @(negedge clk);
        result_value[0] = 32'hA002;
        result_value[1] = 32'hB002;
        @(negedge clk);
        chk("bp_ready_full", 64'(result_ready[0]), 64'd0);
        result_value[0] = 32'hA003;
        result_value[1] = 32'hB003;
        @(negedge clk);
        chk("bp_ready_free", 64'(result_ready[0]), 64'd1);
        result_valid = 4'b0001;
        @(negedge clk);
        clear_inputs();
        repeat (8) @(negedge clk);
        chk("bp_count0", 64'(ulog[0].size()), 64'd4);
        chk("bp_count1", 64'(ulog[1].size()), 64'd3);
        for (int i = 0; i < 4; i++)
            if (ulog[0].size() > i) chk("bp_order0", 64'(ulog[0][i]), 64'(32'hA000 + 32'(i)));
        for (int i = 0; i < 3; i++)
            if (ulog[1].size() > i) chk("bp_order1", 64'(ulog[1][i]), 64'(32'hB001 + 32'(i)));

        // Reset while results for units 2 and 3 are still buffered
        pulse_reset();
        for (int k = 0; k < UNITS; k++) begin
            result_valid[k] = 1'b1;
            result_rs_id[k] = RSW'(20 + k);
            result_value[k] = 32'hBAD0_0000 + 32'(k);
        end
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rmid_valid", 64'(cdb_valid), 64'd0);
        chk("rmid_ready", 64'(result_ready), 64'hF);
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            chk("rmid_idle", 64'(cdb_valid), 64'd0);
        end
        chk("rmid_discard", 64'(saw_bad), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/result_broadcaster.md
# result_broadcaster

Common-data-bus (CDB) transmitter on the producer side of the operand-update interface that the reservation stations consume. It collects completed results, each tagged with the ID of the reservation station that produced it, from up to UNITS execution units. It buffers them per unit and broadcasts one tagged result per cycle, arbitrating round-robin between units. The top level fans `cdb_*` out to every reservation station's per-operand update ports: `operand_valid`, `update_op_rs_id_in` and `update_op_value_in`.

## Interface
Parameters:
- UNITS, default 4: number of producing execution units (≥1).
- FIFO_DEPTH, default 2: result buffer entries per unit (≥1, any integer).
- RS_ID_WIDTH, default 5: width of the reservation-station ID tag.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- result_valid  in  [0:UNITS-1]  unit k offers a result.
- result_ready  out  [0:UNITS-1]  unit k's buffer can accept a result.
- result_rs_id  in  [0:UNITS-1][0:RS_ID_WIDTH-1]  producing RS ID per unit.
- result_value  in  [0:UNITS-1][0:31]  result value per unit.
- cdb_valid  out  1  broadcast valid this cycle.
- cdb_rs_id  out  [0:RS_ID_WIDTH-1]  tag of the broadcast result.
- cdb_value  out  [0:31]  broadcast value.
- cdb_unit  out  [0:$clog2(UNITS)-1]  index of the unit whose result is broadcast (debug/ROB use).

## Operation
- Each unit k owns one FIFO of FIFO_DEPTH entries holding {rs_id, value}.
  - Occupancy counter width is $clog2(FIFO_DEPTH+1).
  - Read and write pointers wrap from FIFO_DEPTH-1 to 0.
- result_ready[k] = (count_k != FIFO_DEPTH). It depends on registered state only and never on the same cycle's pop.
  - A full FIFO therefore refuses a push even in a cycle where it is popped.
- Push: the FIFO is written when result_valid[k] && result_ready[k].
- Arbitration among non-empty FIFOs:
  - Priority starts at pointer rr_ptr and searches rr_ptr, rr_ptr+1, …, wrapping mod UNITS.
  - The first non-empty FIFO wins and is popped that cycle.
  - rr_ptr then becomes (winner+1) mod UNITS.
  - With no winner, rr_ptr holds.
- Broadcast is unconditional: the CDB has no ready signal, and every consumer must sample it in the same cycle.
- Empty FIFO plus push in the same cycle: the entry is visible for arbitration in the next cycle only. There is no same-cycle bypass.
- Simultaneous push and pop on a non-full FIFO: count unchanged, both pointers advance.
- All FIFOs empty: cdb_valid = 0. cdb_rs_id, cdb_value and cdb_unit are driven to 0.
- No result is ever dropped or duplicated. Order within one unit is preserved; order across units is not.

## Timing
- Reset values:
  - cdb_valid = 0, cdb_rs_id = 0, cdb_value = 0, cdb_unit = 0.
  - result_ready = all 1.
  - rr_ptr = 0; all counts and pointers = 0.
- Latency from an accepted result to its broadcast:
  - 1 cycle minimum (uncontended, default build).
  - Worst case with all units contending: FIFO_DEPTH·UNITS cycles.
- Throughput is one broadcast per cycle. Each unit sustains one result per UNITS cycles under full contention, or one per cycle alone.
- Reset asserted mid-operation: all buffered results are discarded. Outputs take their reset values in the cycle after the reset edge.

## Configuration
- CDB_OUTPUT_REG_EN:
  - Defined: cdb_valid, cdb_rs_id, cdb_value and cdb_unit come from a pipeline register stage. Minimum latency becomes 2 cycles and the output register resets to 0.
  - Undefined: outputs are driven combinationally from the winning FIFO head. Minimum latency is 1 cycle.
  - Arbitration, pop timing and result_ready are identical in both builds.

## Structure
- ppc_types gains:
  - constant CDB_DATA_WIDTH = 32.
  - a parameter-free enum/typedef only where it is needed.
- {rs_id, value} stays a local struct, because it depends on RS_ID_WIDTH.
- One sub-module, `result_fifo`: single-clock FIFO with push, pop, count and full/empty.
  - result_broadcaster instantiates it UNITS times in a generate loop.
  - Arbitration and the output stage live in the top module.

## Test plan
- Single result, default build: unit 2 pushes rs_id=5, value=0xDEADBEEF at cycle 0. Required: cdb_valid=1, cdb_rs_id=5, cdb_value=0xDEADBEEF, cdb_unit=2 at cycle 1, then cdb_valid=0.
- Contention: units 0–3 each push one result in the same cycle with rr_ptr=0. Required: broadcasts in unit order 0, 1, 2, 3 on four consecutive cycles.
- Fairness: units 1 and 3 push continuously. Required: broadcasts alternate 1, 3, 1, 3 and neither unit waits more than 2 cycles.
- Backpressure: FIFO_DEPTH=2, unit 0 pushes 3 results in consecutive cycles while unit 1 also keeps its FIFO non-empty. Required: result_ready[0] drops to 0 once count reaches 2, and the third result is accepted only after a pop. All 3 values appear in order.
- Reset mid-stream: two results buffered, rst asserted for one cycle. Required: cdb_valid=0 after the edge, both results never broadcast, result_ready all 1.
- CDB_OUTPUT_REG_EN defined: repeat scenario 1. Required: the same broadcast appears at cycle 2 instead of cycle 1.
